// File: rtl/aes_roundkey_store.sv
// aes_roundkey_store
//   Round-key buffer fed by single_KeyExpansion. Captures the NUM_ROUNDS+1
//   round keys in emission order (slot 0 = cipher key) and serves them by
//   round index to the iterative round engine, so one expansion can serve
//   many data blocks.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   IN_valid    RoundKey holds a key this cycle (from expansion OUT_valid)
//   RoundKey    round key from key expansion
//   clear       discard stored keys, return to EMPTY
//   rd_en       read request, response one cycle later
//   rd_round    round index to read, 0..NUM_ROUNDS
//   rd_dec      (AES_RKS_REVERSE_EN only) read slot NUM_ROUNDS-rd_round
//   keys_ready  all NUM_ROUNDS+1 keys stored
//   rd_valid    rd_key valid, one-cycle pulse
//   rd_key      requested round key; holds until next read
//   rd_err      one-cycle pulse on an illegal read
//   ovf_err     one-cycle pulse when a key arrives while READY
//
// Build option
//   AES_RKS_REVERSE_EN  adds rd_dec for reverse-order (decipher) indexing.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_EMPTY   | no keys stored; next key lands in slot 0
// ST_FILLING | slots 0..wr_cnt-1 written; waiting for the rest
// ST_READY   | all slots written; reads legal; further keys rejected

module aes_roundkey_store #(
   parameter int NUM_ROUNDS = 10,
   parameter int KEY_W      = 128
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             IN_valid,
   input  logic [KEY_W-1:0] RoundKey,
   input  logic             clear,
   input  logic             rd_en,
   input  logic [3:0]       rd_round,
`ifdef AES_RKS_REVERSE_EN
   input  logic             rd_dec,
`endif
   output logic             keys_ready,
   output logic             rd_valid,
   output logic [KEY_W-1:0] rd_key,
   output logic             rd_err,
   output logic             ovf_err
);

   localparam logic [3:0] LAST_SLOT = 4'(NUM_ROUNDS);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_READY   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       wr_cnt;
   logic [3:0]       wr_cnt_nxt;
   logic             wr_en;
   logic [3:0]       wr_slot;
   logic             ovf_nxt;
   logic             rd_legal;
   logic [3:0]       rd_idx;

   // Storage carries no reset: reads are gated by rd_legal, which is only
   // true once every slot has been written since the last reset/clear.
   logic [KEY_W-1:0] key_mem [0:NUM_ROUNDS];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_EMPTY;
         wr_cnt <= 4'd0;
      end else begin
         state  <= state_nxt;
         wr_cnt <= wr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      wr_cnt_nxt = wr_cnt;
      wr_en      = 1'b0;
      wr_slot    = wr_cnt;
      ovf_nxt    = 1'b0;
      if (clear) begin
         // clear beats a coincident key: the key is dropped, no overflow
         state_nxt  = ST_EMPTY;
         wr_cnt_nxt = 4'd0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (IN_valid) begin
                  wr_en      = 1'b1;
                  wr_slot    = 4'd0;
                  wr_cnt_nxt = 4'd1;
                  state_nxt  = ST_FILLING;
               end
            end
            ST_FILLING: begin
               if (IN_valid) begin
                  wr_en      = 1'b1;
                  wr_cnt_nxt = wr_cnt + 4'd1;
                  if (wr_cnt == LAST_SLOT) begin
                     state_nxt = ST_READY;
                  end
               end
            end
            ST_READY: begin
               ovf_nxt = IN_valid;
            end
            default: begin
               state_nxt  = ST_EMPTY;
               wr_cnt_nxt = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         key_mem[wr_slot] <= RoundKey;
      end
   end

   // Legality uses the pre-clear state and the raw rd_round.
   assign rd_legal = (state == ST_READY) && (rd_round <= LAST_SLOT);

`ifdef AES_RKS_REVERSE_EN
   assign rd_idx = rd_dec ? (LAST_SLOT - rd_round) : rd_round;
`else
   assign rd_idx = rd_round;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         rd_key   <= '0;
         ovf_err  <= 1'b0;
      end else begin
         rd_valid <= rd_en && rd_legal;
         rd_err   <= rd_en && !rd_legal;
         ovf_err  <= ovf_nxt;
         if (rd_en) begin
            rd_key <= rd_legal ? key_mem[rd_idx] : '0;
         end
      end
   end

   assign keys_ready = (state == ST_READY);

endmodule

// File: tb/tb_aes_roundkey_store.sv
// tb_aes_roundkey_store
//   Directed bench for aes_roundkey_store using the FIPS-197 expansion of
//   key 2b7e151628aed2a6abf7158809cf4f3c. A count-of-keys model tracks what
//   the outputs must be and is compared on every falling clock edge; literal
//   expectations pin the model at the key points.

module tb_aes_roundkey_store;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         IN_valid = 1'b0;
   logic [127:0] RoundKey = '0;
   logic         clear = 1'b0;
   logic         rd_en = 1'b0;
   logic [3:0]   rd_round = 4'd0;
`ifdef AES_RKS_REVERSE_EN
   logic         rd_dec = 1'b0;
`endif
   logic         keys_ready;
   logic         rd_valid;
   logic [127:0] rd_key;
   logic         rd_err;
   logic         ovf_err;

   int checks = 0;
   int errors = 0;

   logic [127:0] fips [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   aes_roundkey_store #(.NUM_ROUNDS(10), .KEY_W(128)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .IN_valid   (IN_valid),
      .RoundKey   (RoundKey),
      .clear      (clear),
      .rd_en      (rd_en),
      .rd_round   (rd_round),
`ifdef AES_RKS_REVERSE_EN
      .rd_dec     (rd_dec),
`endif
      .keys_ready (keys_ready),
      .rd_valid   (rd_valid),
      .rd_key     (rd_key),
      .rd_err     (rd_err),
      .ovf_err    (ovf_err)
   );

   always #5 clk = ~clk;

   // ---------------- model ----------------
   int           m_n;
   logic [127:0] m_mem [0:10];
   logic         m_valid;
   logic         m_err;
   logic         m_ovf;
   logic [127:0] m_key;

   function automatic int m_slot();
      int s;
      s = int'(rd_round);
`ifdef AES_RKS_REVERSE_EN
      if (rd_dec) s = 10 - s;
`endif
      return s;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_n     <= 0;
         m_valid <= 1'b0;
         m_err   <= 1'b0;
         m_ovf   <= 1'b0;
         m_key   <= '0;
      end else begin
         m_ovf   <= IN_valid && !clear && (m_n == 11);
         m_valid <= rd_en && (m_n == 11) && (rd_round <= 4'd10);
         m_err   <= rd_en && !((m_n == 11) && (rd_round <= 4'd10));
         if (rd_en) begin
            if ((m_n == 11) && (rd_round <= 4'd10)) m_key <= m_mem[m_slot()];
            else                                   m_key <= '0;
         end
         if (clear) begin
            m_n <= 0;
         end else if (IN_valid && m_n < 11) begin
            m_mem[m_n] <= RoundKey;
            m_n        <= m_n + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("keys_ready", {127'd0, keys_ready}, {127'd0, m_n == 11});
      chk("rd_valid",   {127'd0, rd_valid},   {127'd0, m_valid});
      chk("rd_err",     {127'd0, rd_err},     {127'd0, m_err});
      chk("ovf_err",    {127'd0, ovf_err},    {127'd0, m_ovf});
      chk("rd_key",     rd_key,               m_key);
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [127:0] k);
      IN_valid = 1'b1;
      RoundKey = k;
      step();
      IN_valid = 1'b0;
   endtask

   task automatic rd(input logic [3:0] r);
      rd_en    = 1'b1;
      rd_round = r;
      step();
      rd_en    = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      #1;
      chk("reset keys_ready", {127'd0, keys_ready}, 128'd0);
      chk("reset rd_key", rd_key, 128'd0);
      step();

      // partial fill, illegal read in FILLING, gaps
      for (int i = 0; i < 5; i++) push(fips[i]);
      rd(4'd3);
      chk("fill rd_err", {127'd0, rd_err}, 128'd1);
      chk("fill rd_valid", {127'd0, rd_valid}, 128'd0);
      chk("fill rd_key", rd_key, 128'd0);
      step(); step();
      for (int i = 5; i < 11; i++) begin
         chk("not yet ready", {127'd0, keys_ready}, 128'd0);
         push(fips[i]);
      end
      chk("ready after 11", {127'd0, keys_ready}, 128'd1);

      rd(4'd1);
      chk("rd1 valid", {127'd0, rd_valid}, 128'd1);
      chk("rd1 key", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
      rd(4'd10);
      chk("rd10 key", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      step();
      chk("rd_key holds", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd_en = 1'b1;
      for (int r = 0; r <= 10; r++) begin
         rd_round = 4'(r);
         step();
      end
      rd_en = 1'b0;
      rd(4'd11);
      chk("rd11 err", {127'd0, rd_err}, 128'd1);
      rd(4'd15);

      // overflow
      push({128{1'b1}});
      chk("ovf pulse", {127'd0, ovf_err}, 128'd1);
      step();
      chk("ovf once", {127'd0, ovf_err}, 128'd0);
      rd(4'd10);
      chk("post-ovf rd10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // clear with a read: read sees pre-clear READY
      clear = 1'b1;
      rd(4'd4);
      clear = 1'b0;
      chk("clear+rd valid", {127'd0, rd_valid}, 128'd1);
      chk("clear+rd key", rd_key, fips[4]);
      chk("clear drops ready", {127'd0, keys_ready}, 128'd0);

      // clear colliding with IN_valid at wr_cnt=5
      for (int i = 0; i < 5; i++) push(fips[i]);
      clear = 1'b1;
      push({128{1'b1}});
      clear = 1'b0;
      chk("collide ovf", {127'd0, ovf_err}, 128'd0);
      chk("collide ready", {127'd0, keys_ready}, 128'd0);
      for (int i = 0; i < 11; i++) push(fips[10 - i]);
      rd(4'd0);
      chk("refill rd0", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd_en = 1'b1;
      for (int r = 10; r >= 0; r--) begin
         rd_round = 4'(r);
         step();
      end
      rd_en = 1'b0;

      // async reset mid-fill
      clear = 1'b1;
      step();
      clear = 1'b0;
      for (int i = 0; i < 6; i++) push(fips[i]);
      rd(4'd0);
      chk("pre-reset rd_err", {127'd0, rd_err}, 128'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("async rd_err", {127'd0, rd_err}, 128'd0);
      chk("async keys_ready", {127'd0, keys_ready}, 128'd0);
      step();
      reset_n = 1'b1;
      step();
      for (int i = 0; i < 11; i++) push(fips[i]);
      chk("refill after reset", {127'd0, keys_ready}, 128'd1);
      rd(4'd0);
      chk("reset refill rd0", rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);

`ifdef AES_RKS_REVERSE_EN
      rd_dec = 1'b1;
      rd(4'd0);
      chk("dec rd0", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd(4'd10);
      chk("dec rd10", rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      rd(4'd11);
      chk("dec rd11 err", {127'd0, rd_err}, 128'd1);
      rd_dec = 1'b0;
`endif

      step(); step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_roundkey_store.md
Name: aes_roundkey_store

Overview:
- Round-key buffer sitting directly downstream of single_KeyExpansion.
- Captures the NUM_ROUNDS+1 round keys that single_KeyExpansion emits in order (round 0 = cipher key, then rounds 1..NUM_ROUNDS), one per OUT_valid cycle.
- Serves the keys by round index to the iterative cipher/decipher round engine.
- Decouples key expansion timing from data-path round timing, so one expansion serves many blocks.

Parameters:
- NUM_ROUNDS, 10, number of AES rounds; the store holds NUM_ROUNDS+1 keys.
- KEY_W, 128, round-key width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- IN_valid  input  1  round key present on RoundKey this cycle; driven by single_KeyExpansion OUT_valid.
- RoundKey  input  KEY_W  round key from single_KeyExpansion.
- clear  input  1  discard stored keys and return to EMPTY.
- rd_en  input  1  read request.
- rd_round  input  4  round index to read, 0..NUM_ROUNDS.
- keys_ready  output  1  all NUM_ROUNDS+1 keys stored.
- rd_valid  output  1  rd_key valid; one-cycle pulse.
- rd_key  output  KEY_W  requested round key.
- rd_err  output  1  one-cycle pulse on an illegal read.
- ovf_err  output  1  one-cycle pulse when IN_valid arrives in READY.

Behaviour:
- Reset (async, reset_n=0):
  - state=EMPTY, wr_cnt=0.
  - keys_ready=0, rd_valid=0, rd_key=0, rd_err=0, ovf_err=0.
  - Key storage contents are don't-care, but must never be visible on rd_key.
- State machine:
  - EMPTY: IN_valid writes RoundKey to slot 0, wr_cnt<=1, go to FILLING.
  - FILLING: IN_valid writes slot wr_cnt, wr_cnt<=wr_cnt+1. Writing slot NUM_ROUNDS goes to READY; keys_ready=1 from the next cycle.
  - READY: keys held indefinitely. IN_valid is ignored (storage unchanged) and ovf_err pulses high for one cycle.
  - Gaps between IN_valid pulses are allowed in FILLING with no timeout.
- clear (any state): next state EMPTY, wr_cnt=0, keys_ready=0 next cycle.
- clear and IN_valid in the same cycle: clear wins, the key is dropped, no ovf_err.
- Reads:
  - rd_en sampled at a rising edge; response registered one cycle later (latency 1).
  - Legal read: state READY and rd_round<=NUM_ROUNDS. Gives rd_valid=1 and rd_key=slot[rd_round].
  - Illegal read: state not READY, or rd_round>NUM_ROUNDS. Gives rd_valid=0, rd_err=1, rd_key=0.
  - Back-to-back reads every cycle are supported at full throughput.
- rd_key holds its last value when rd_en=0; it is cleared to 0 only by reset or an illegal read.
- clear together with rd_en: the read is evaluated against the pre-clear state, so a legal read in READY still returns data.
- Reset mid-fill: all progress is lost; the next IN_valid is treated as round 0.
- Widths:
  - wr_cnt is 4 bits and never exceeds NUM_ROUNDS+1.
  - rd_round is compared unsigned; values 11..15 are errors for NUM_ROUNDS=10.

Optional Feature:
- Macro: AES_RKS_REVERSE_EN.
- When defined:
  - Adds input port rd_dec (1 bit).
  - On a read with rd_dec=1, slot[NUM_ROUNDS-rd_round] is returned, so the decipher engine can step rd_round 0..NUM_ROUNDS.
  - Legality check and error behaviour are unchanged; the range check uses the raw rd_round.
- When undefined:
  - No rd_dec port; reads are always forward-indexed.

Test Plan:
- Fill and read: reset, then 11 IN_valid pulses of the FIPS-197 expansion of key 2b7e151628aed2a6abf7158809cf4f3c.
  - keys_ready=1 one cycle after the 11th pulse.
  - rd_round=1 gives rd_key=a0fafe1788542cb123a339392a6c7605 with rd_valid the next cycle.
  - rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- Illegal reads:
  - rd_en with rd_round=3 in FILLING gives rd_err=1, rd_valid=0, rd_key=0.
  - rd_round=11 in READY gives rd_err=1.
- Overflow: 12th IN_valid with RoundKey=all-ones in READY.
  - ovf_err pulses once.
  - Subsequent read of rd_round=10 still returns d014f9a8...0ca6.
- Clear collision: clear and IN_valid asserted together in FILLING (wr_cnt=5).
  - State becomes EMPTY, keys_ready=0.
  - The next 11 keys refill from slot 0 and read back correctly.
- Async reset mid-fill: reset_n low between clock edges after 6 keys.
  - Outputs go to 0 immediately.
  - After release, 11 new keys fill normally.
- With AES_RKS_REVERSE_EN: in READY, rd_dec=1 and rd_round=0 returns d014f9a8...0ca6; rd_dec=1 and rd_round=10 returns 2b7e1516...4f3c.
